// File: rtl/ddram_avl_bridge_if.sv
// Bus bundles for the ao486 ddram bridge: 32-bit Avalon-MM side and 64-bit DDRAM side.
interface ddram_avl_bridge_avl_if;
  logic [29:0] avl_address;
  logic [7:0]  avl_burstcount;
  logic        avl_read;
  logic        avl_write;
  logic [31:0] avl_writedata;
  logic [3:0]  avl_byteenable;
  logic        avl_waitrequest;
  logic [31:0] avl_readdata;
  logic        avl_readdatavalid;

  modport master (output avl_address, avl_burstcount, avl_read, avl_write, avl_writedata,
                  avl_byteenable, input avl_waitrequest, avl_readdata, avl_readdatavalid);
  modport slave  (input avl_address, avl_burstcount, avl_read, avl_write, avl_writedata,
                  avl_byteenable, output avl_waitrequest, avl_readdata, avl_readdatavalid);
endinterface

interface ddram_avl_bridge_ddr_if;
  logic        DDRAM_BUSY;
  logic [28:0] DDRAM_ADDR;
  logic [7:0]  DDRAM_BURSTCNT;
  logic        DDRAM_RD;
  logic        DDRAM_WE;
  logic [63:0] DDRAM_DIN;
  logic [7:0]  DDRAM_BE;
  logic [63:0] DDRAM_DOUT;
  logic        DDRAM_DOUT_READY;

  modport master (input DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
                  output DDRAM_ADDR, DDRAM_BURSTCNT, DDRAM_RD, DDRAM_WE, DDRAM_DIN, DDRAM_BE);
  modport slave  (output DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
                  input DDRAM_ADDR, DDRAM_BURSTCNT, DDRAM_RD, DDRAM_WE, DDRAM_DIN, DDRAM_BE);
endinterface

// File: rtl/ddram_avl_bridge.sv
// 32-bit Avalon burst master to 64-bit DDRAM port: packs write words into qwords,
// unpacks read qwords through a FIFO. One transaction in flight.
module ddram_avl_bridge #(
  parameter int MAX_BURST = 128,
  parameter int FIFO_AW   = 7
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  ddram_avl_bridge_avl_if.slave   avl,
  ddram_avl_bridge_ddr_if.master  ddr
);
  typedef enum logic [2:0] {IDLE, RD_CMD, RD_DATA, WR_COLLECT, WR_ISSUE} state_t;
  localparam logic [7:0] MAXB = 8'(MAX_BURST);

  state_t             state;
  logic [7:0]         n_req;
  logic [8:0]         q_sum;
  logic [7:0]         words_left;
  logic               half;
  logic [63:0]        fifo_mem [2**FIFO_AW];
  logic [FIFO_AW:0]   wr_ptr, rd_ptr;
  logic               fifo_empty, push, emit, pop;
  logic [63:0]        head;

  always_comb begin
    n_req = avl.avl_burstcount;
    if (n_req == 8'd0)     n_req = 8'd1;
    else if (n_req > MAXB) n_req = MAXB;
    q_sum = 9'(avl.avl_address[0]) + 9'(n_req) + 9'd1;
  end

  // Only data for the active read is kept; stray strobes elsewhere are dropped.
  assign push       = (state == RD_DATA) && ddr.DDRAM_DOUT_READY;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign head       = fifo_mem[rd_ptr[FIFO_AW-1:0]];
  assign emit       = (state == RD_DATA) && !fifo_empty;
  assign pop        = emit && (half || words_left == 8'd1);

  always_ff @(posedge clk_sys)
    if (push) fifo_mem[wr_ptr[FIFO_AW-1:0]] <= ddr.DDRAM_DOUT;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state                 <= IDLE;
      wr_ptr                <= '0;
      rd_ptr                <= '0;
      words_left            <= '0;
      half                  <= 1'b0;
      avl.avl_waitrequest   <= 1'b1;
      avl.avl_readdata      <= '0;
      avl.avl_readdatavalid <= 1'b0;
      ddr.DDRAM_ADDR        <= '0;
      ddr.DDRAM_BURSTCNT    <= '0;
      ddr.DDRAM_RD          <= 1'b0;
      ddr.DDRAM_WE          <= 1'b0;
      ddr.DDRAM_DIN         <= '0;
      ddr.DDRAM_BE          <= '0;
    end else begin
      avl.avl_readdatavalid <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case (state)
        IDLE: begin
          avl.avl_waitrequest <= 1'b0;
          if (!avl.avl_waitrequest && avl.avl_read) begin
            ddr.DDRAM_ADDR      <= avl.avl_address[29:1];
            ddr.DDRAM_BURSTCNT  <= q_sum[8:1];
            words_left          <= n_req;
            half                <= avl.avl_address[0];
            ddr.DDRAM_RD        <= 1'b1;
            avl.avl_waitrequest <= 1'b1;
            state               <= RD_CMD;
          end else if (!avl.avl_waitrequest && avl.avl_write) begin
            ddr.DDRAM_ADDR     <= avl.avl_address[29:1];
            ddr.DDRAM_BURSTCNT <= q_sum[8:1];
            words_left         <= n_req - 8'd1;
            if (avl.avl_address[0]) begin
              ddr.DDRAM_DIN <= {avl.avl_writedata, 32'h0};
              ddr.DDRAM_BE  <= {avl.avl_byteenable, 4'h0};
            end else begin
              ddr.DDRAM_DIN <= {32'h0, avl.avl_writedata};
              ddr.DDRAM_BE  <= {4'h0, avl.avl_byteenable};
            end
            if (avl.avl_address[0] || n_req == 8'd1) begin
              ddr.DDRAM_WE        <= 1'b1;
              avl.avl_waitrequest <= 1'b1;
              half                <= 1'b0;
              state               <= WR_ISSUE;
            end else begin
              half  <= 1'b1;
              state <= WR_COLLECT;
            end
          end
        end
        RD_CMD:
          if (!ddr.DDRAM_BUSY) begin
            ddr.DDRAM_RD <= 1'b0;
            state        <= RD_DATA;
          end
        RD_DATA:
          if (emit) begin
            avl.avl_readdata      <= half ? head[63:32] : head[31:0];
            avl.avl_readdatavalid <= 1'b1;
            words_left            <= words_left - 8'd1;
            half                  <= !pop;
            if (words_left == 8'd1) begin
              avl.avl_waitrequest <= 1'b0;
              state               <= IDLE;
            end
          end
        WR_COLLECT:
          if (avl.avl_write) begin
            if (half) begin
              ddr.DDRAM_DIN[63:32] <= avl.avl_writedata;
              ddr.DDRAM_BE[7:4]    <= avl.avl_byteenable;
            end else begin
              ddr.DDRAM_DIN[31:0]  <= avl.avl_writedata;
              ddr.DDRAM_BE[3:0]    <= avl.avl_byteenable;
            end
            words_left <= words_left - 8'd1;
            if (half || words_left == 8'd1) begin
              ddr.DDRAM_WE        <= 1'b1;
              avl.avl_waitrequest <= 1'b1;
              state               <= WR_ISSUE;
            end else begin
              half <= 1'b1;
            end
          end
        WR_ISSUE:
          if (!ddr.DDRAM_BUSY) begin
            ddr.DDRAM_WE        <= 1'b0;
            ddr.DDRAM_BE        <= '0;
            ddr.DDRAM_DIN       <= '0;
            half                <= 1'b0;
            avl.avl_waitrequest <= 1'b0;
            state               <= (words_left != 8'd0) ? WR_COLLECT : IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ddram_avl_bridge.sv
// Directed bench for ddram_avl_bridge: read unpacking, write packing, DDR stalls, reset abort.
module tb_ddram_avl_bridge;
  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_sys = ~clk_sys;

  ddram_avl_bridge_avl_if avl();
  ddram_avl_bridge_ddr_if ddr();

  ddram_avl_bridge #(.MAX_BURST(128), .FIFO_AW(7)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .avl     (avl),
    .ddr     (ddr)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  logic [31:0] rq[$];
  int          rcyc[$];
  logic [63:0] wdin[$];
  logic [7:0]  wbe[$];
  logic [28:0] waddr[$];
  logic [7:0]  wbc[$];

  always @(negedge clk_sys) begin
    if (avl.avl_readdatavalid === 1'b1) begin
      rq.push_back(avl.avl_readdata);
      rcyc.push_back(cyc);
    end
    if (ddr.DDRAM_WE === 1'b1 && ddr.DDRAM_BUSY === 1'b0) begin
      wdin.push_back(ddr.DDRAM_DIN);
      wbe.push_back(ddr.DDRAM_BE);
      waddr.push_back(ddr.DDRAM_ADDR);
      wbc.push_back(ddr.DDRAM_BURSTCNT);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_accept(input string tag);
    int k = 0;
    while (avl.avl_waitrequest !== 1'b0 && k < 50) begin step(); k++; end
    chk(tag, avl.avl_waitrequest, 1'b0);
    step();
  endtask

  task automatic avl_rd(input logic [29:0] a, input logic [7:0] bc);
    avl.avl_address    = a;
    avl.avl_burstcount = bc;
    avl.avl_read       = 1'b1;
    wait_accept("rd_accept");
    avl.avl_read = 1'b0;
  endtask

  task automatic avl_wr(input logic [29:0] a, input logic [7:0] bc, input int nb,
                        input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [3:0] be);
    avl.avl_address    = a;
    avl.avl_burstcount = bc;
    avl.avl_byteenable = be;
    for (int i = 0; i < nb; i++) begin
      avl.avl_write     = 1'b1;
      avl.avl_writedata = (i == 0) ? d0 : (i == 1) ? d1 : d2;
      wait_accept("wr_accept");
    end
    avl.avl_write = 1'b0;
  endtask

  task automatic wait_rd_cmd(input logic [28:0] ea, input logic [7:0] ebc);
    int k = 0;
    while (ddr.DDRAM_RD !== 1'b1 && k < 50) begin step(); k++; end
    chk("rd_cmd_seen", ddr.DDRAM_RD, 1'b1);
    chk("rd_cmd_addr", ddr.DDRAM_ADDR, ea);
    chk("rd_cmd_bcnt", ddr.DDRAM_BURSTCNT, ebc);
    step();
    chk("rd_cmd_drop", ddr.DDRAM_RD, 1'b0);
  endtask

  task automatic ddr_push(input logic [63:0] q);
    ddr.DDRAM_DOUT       = q;
    ddr.DDRAM_DOUT_READY = 1'b1;
    step();
    ddr.DDRAM_DOUT_READY = 1'b0;
  endtask

  task automatic wait_words(input int n);
    int k = 0;
    while (rq.size() < n && k < 400) begin step(); k++; end
    chk("word_count", rq.size(), n);
  endtask

  task automatic wait_wbeats(input int n);
    int k = 0;
    while (wdin.size() < n && k < 50) begin step(); k++; end
    chk("wr_beat_count", wdin.size(), n);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected done");
    $fatal(1, "bench timeout");
  end

  initial begin
    int t0;
    avl.avl_address = '0; avl.avl_burstcount = '0; avl.avl_read = 1'b0;
    avl.avl_write = 1'b0; avl.avl_writedata = '0; avl.avl_byteenable = '0;
    ddr.DDRAM_BUSY = 1'b0; ddr.DDRAM_DOUT = '0; ddr.DDRAM_DOUT_READY = 1'b0;

    // reset values
    repeat (3) step();
    chk("rst_waitreq", avl.avl_waitrequest, 1'b1);
    chk("rst_rdv", avl.avl_readdatavalid, 1'b0);
    chk("rst_rd", ddr.DDRAM_RD, 1'b0);
    chk("rst_we", ddr.DDRAM_WE, 1'b0);
    chk("rst_addr", ddr.DDRAM_ADDR, 29'h0);
    chk("rst_bcnt", ddr.DDRAM_BURSTCNT, 8'h0);
    chk("rst_be", ddr.DDRAM_BE, 8'h0);
    reset_n = 1'b1;
    step();
    chk("idle_waitreq", avl.avl_waitrequest, 1'b0);

    // aligned read, 4 words over 2 qwords
    avl_rd(30'h100, 8'd4);
    wait_rd_cmd(29'h80, 8'd2);
    t0 = cyc;
    ddr_push(64'h2222_2222_1111_1111);
    ddr_push(64'h4444_4444_3333_3333);
    wait_words(4);
    if (rq.size() == 4) begin
      chk("rd4_w0", rq[0], 32'h1111_1111);
      chk("rd4_w1", rq[1], 32'h2222_2222);
      chk("rd4_w2", rq[2], 32'h3333_3333);
      chk("rd4_w3", rq[3], 32'h4444_4444);
      chk("rd4_latency", rcyc[0] - t0, 2);
    end
    step();
    chk("rd4_back_idle", avl.avl_waitrequest, 1'b0);
    rq.delete(); rcyc.delete();

    // odd-address read: skip lo of first, hi of last
    avl_rd(30'h101, 8'd2);
    wait_rd_cmd(29'h80, 8'd2);
    ddr_push(64'h0000_00A1_0000_00A0);
    ddr_push(64'h0000_00B1_0000_00B0);
    wait_words(2);
    repeat (4) step();
    chk("rdodd_count", rq.size(), 2);
    if (rq.size() >= 2) begin
      chk("rdodd_w0", rq[0], 32'hA1);
      chk("rdodd_w1", rq[1], 32'hB0);
    end
    rq.delete(); rcyc.delete();

    // odd-address 3-word write
    avl_wr(30'h201, 8'd3, 3, 32'h11, 32'h22, 32'h33, 4'hF);
    wait_wbeats(2);
    if (wdin.size() >= 2) begin
      chk("wr3_addr0", waddr[0], 29'h100);
      chk("wr3_bcnt0", wbc[0], 8'd2);
      chk("wr3_din0_hi", wdin[0][63:32], 32'h11);
      chk("wr3_be0", wbe[0], 8'hF0);
      chk("wr3_addr1", waddr[1], 29'h100);
      chk("wr3_din1", wdin[1], 64'h0000_0033_0000_0022);
      chk("wr3_be1", wbe[1], 8'hFF);
    end
    step();
    chk("wr3_back_idle", avl.avl_waitrequest, 1'b0);
    wdin.delete(); wbe.delete(); waddr.delete(); wbc.delete();

    // burstcount 0 behaves as single word
    avl_wr(30'h40, 8'd0, 1, 32'h1234_5678, 32'h0, 32'h0, 4'h3);
    wait_wbeats(1);
    if (wdin.size() >= 1) begin
      chk("wr0_bcnt", wbc[0], 8'd1);
      chk("wr0_be", wbe[0], 8'h03);
      chk("wr0_din_lo", wdin[0][31:0], 32'h1234_5678);
    end
    step();
    wdin.delete(); wbe.delete(); waddr.delete(); wbc.delete();

    // single write held by DDR busy for 5 cycles
    ddr.DDRAM_BUSY = 1'b1;
    avl_wr(30'h300, 8'd1, 1, 32'hDEAD_BEEF, 32'h0, 32'h0, 4'hF);
    for (int i = 1; i <= 6; i++) begin
      chk("busy_we_held", ddr.DDRAM_WE, 1'b1);
      chk("busy_waitreq", avl.avl_waitrequest, 1'b1);
      if (i == 6) ddr.DDRAM_BUSY = 1'b0;
      step();
    end
    chk("busy_we_drop", ddr.DDRAM_WE, 1'b0);
    chk("busy_waitreq_drop", avl.avl_waitrequest, 1'b0);
    chk("busy_beats", wdin.size(), 1);
    if (wdin.size() >= 1) begin
      chk("busy_addr", waddr[0], 29'h180);
      chk("busy_be", wbe[0], 8'h0F);
      chk("busy_din_lo", wdin[0][31:0], 32'hDEAD_BEEF);
    end
    wdin.delete(); wbe.delete(); waddr.delete(); wbc.delete();

    // max burst, qword every cycle
    avl_rd(30'h0, 8'd128);
    wait_rd_cmd(29'h0, 8'd64);
    for (int i = 0; i < 64; i++)
      ddr_push({32'h5000_0000 + 32'(2*i+1), 32'h5000_0000 + 32'(2*i)});
    wait_words(128);
    if (rq.size() == 128) begin
      for (int j = 0; j < 128; j++) chk("n128_word", rq[j], 32'h5000_0000 + 32'(j));
      chk("n128_contiguous", rcyc[127] - rcyc[0], 127);
    end
    rq.delete(); rcyc.delete();

    // burstcount above MAX_BURST is clipped; reset aborts the read
    avl_rd(30'h10, 8'd200);
    wait_rd_cmd(29'h8, 8'd64);
    ddr_push(64'h0000_00EE_0000_00DD);
    reset_n = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    step();
    for (int i = 0; i < 3; i++) ddr_push(64'hFFFF_0000_FFFF_0000 + 64'(i));
    repeat (4) step();
    chk("abort_no_valid", rq.size(), 0);
    chk("abort_idle", avl.avl_waitrequest, 1'b0);
    rq.delete(); rcyc.delete();

    avl_rd(30'h11, 8'd2);
    wait_rd_cmd(29'h8, 8'd2);
    ddr_push(64'h0000_00C1_0000_00C0);
    ddr_push(64'h0000_00D1_0000_00D0);
    wait_words(2);
    if (rq.size() >= 2) begin
      chk("post_rst_w0", rq[0], 32'hC1);
      chk("post_rst_w1", rq[1], 32'hD0);
    end
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
